// File: rtl/mojo_serial_block_fifo_if.sv
// Block-level bus between receiver, block FIFO and transmitter.
// Optional drop_count signal exists only with MOJO_BLOCK_FIFO_STATS_EN.
interface mojo_serial_block_fifo_if #(
  parameter int W = 320
);
  // Handshake: new_in_block is a one-cycle strobe qualifying in_block (no back-pressure,
  // a push while full is dropped); new_out_block is a one-cycle strobe, out_block holds
  // until the next strobe; out_busy high from the transmitter blocks further issues.
  logic [W-1:0] in_block;
  logic         new_in_block;
  logic [W-1:0] out_block;
  logic         new_out_block;
  logic         out_busy;
  logic         empty;
  logic         full;
  logic         overflow;
`ifdef MOJO_BLOCK_FIFO_STATS_EN
  logic [7:0]   drop_count;

  modport master (
    output in_block, new_in_block, out_busy,
    input  out_block, new_out_block, empty, full, overflow, drop_count
  );

  modport slave (
    input  in_block, new_in_block, out_busy,
    output out_block, new_out_block, empty, full, overflow, drop_count
  );
`else
  modport master (
    output in_block, new_in_block, out_busy,
    input  out_block, new_out_block, empty, full, overflow
  );

  modport slave (
    input  in_block, new_in_block, out_busy,
    output out_block, new_out_block, empty, full, overflow
  );
`endif
endinterface

// File: rtl/mojo_serial_block_fifo.sv
// Whole-block FIFO between serial block receiver and transmitter, metered by out_busy.
// Optional feature macro: MOJO_BLOCK_FIFO_STATS_EN adds a saturating drop_count.
module mojo_serial_block_fifo #(
  parameter int BLOCK_BYTES  = 40,
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  mojo_serial_block_fifo_if.slave  bus,
  output logic [1:0]               dbg_state
);
  localparam int W  = BLOCK_BYTES * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          pop, push, drop;

  assign dbg_state = state;

  // The pop is taken on the edge entering ISSUE so that out_block and the
  // issue strobe become visible together.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.empty && !bus.out_busy) begin
          state_nxt = ST_ISSUE;
          pop       = 1'b1;
        end
      end
      ST_ISSUE:     state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (bus.out_busy)                          state_nxt = ST_WAIT_IDLE;
        else if (tmo_cnt == TW'(BUSY_TIMEOUT - 1)) state_nxt = ST_IDLE;
      end
      ST_WAIT_IDLE: if (!bus.out_busy) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  assign push = bus.new_in_block && (!bus.full || pop);
  assign drop = bus.new_in_block && bus.full && !pop;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_block;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      tmo_cnt           <= '0;
      bus.empty         <= 1'b1;
      bus.full          <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.out_block     <= '0;
      bus.new_out_block <= 1'b0;
    end else begin
      state             <= state_nxt;
      count             <= count_nxt;
      bus.empty         <= (count_nxt == '0);
      bus.full          <= (count_nxt == (AW+1)'(DEPTH));
      bus.new_out_block <= pop;
      tmo_cnt           <= (state == ST_WAIT_BUSY) ? tmo_cnt + 1'b1 : '0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        bus.out_block <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (drop) bus.overflow <= 1'b1;
    end
  end

`ifdef MOJO_BLOCK_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                                  bus.drop_count <= '0;
    else if (drop && bus.drop_count != 8'hFF) bus.drop_count <= bus.drop_count + 1'b1;
  end
`endif
endmodule
